// File: rtl/reg_file_scoreboard_pkg.sv
// Shared constants for the 8x16 register file and its pending-write scoreboard.
package reg_file_scoreboard_pkg;
  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 3;
  localparam int unsigned NREG       = 2 ** ADDR_W_DEF;
  localparam logic [ADDR_W_DEF-1:0] REG_ZERO = 3'd0;
endpackage

// File: rtl/reg_file_scoreboard_sb_tracker.sv
// Pending-write scoreboard: busy bits, write-back clear, issue set and stall detection.
module sb_tracker
  import reg_file_scoreboard_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic                 iss_valid,
  input  logic [ADDR_W-1:0]    iss_dest,
  input  logic                 iss_wb,
  input  logic [ADDR_W-1:0]    iss_src_a,
  input  logic [ADDR_W-1:0]    iss_src_b,
  output logic                 hazard,
  output logic [2**ADDR_W-1:0] busy_vec
);
  localparam int unsigned NR = 2 ** ADDR_W;

  logic [NR-1:0] busy_q;
  logic [NR-1:0] busy_clr;
  logic [NR-1:0] busy_set;
  logic [NR-1:0] eff;
  logic          dest_is_r0;

  assign dest_is_r0 = R0_ZERO && (iss_dest == ADDR_W'(REG_ZERO));

  always_comb begin
    busy_clr = '0;
    if (wr_en) busy_clr[wr_addr] = 1'b1;
    // A write-back landing this cycle is bypassed to readers, so it no longer blocks issue.
    eff = busy_q & ~busy_clr;
    if (R0_ZERO) eff[0] = 1'b0;
    hazard = iss_valid & (eff[iss_src_a] | eff[iss_src_b] | (iss_wb & eff[iss_dest]));
    busy_set = '0;
    if (iss_valid && iss_wb && !hazard && !dest_is_r0) busy_set[iss_dest] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      // Set is OR-ed last so it wins over a same-cycle clear.
      busy_q <= (busy_q & ~busy_clr) | busy_set;
    end
  end

  assign busy_vec = busy_q;
endmodule

// File: rtl/reg_file_scoreboard.sv
// 8x16 register file with write-through bypass reads and a pending-write scoreboard.
module reg_file_scoreboard
  import reg_file_scoreboard_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter bit          R0_ZERO = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    rd_addr_a,
  output logic [DATA_W-1:0]    rd_data_a,
  input  logic [ADDR_W-1:0]    rd_addr_b,
  output logic [DATA_W-1:0]    rd_data_b,
  input  logic                 wr_en,
  input  logic [ADDR_W-1:0]    wr_addr,
  input  logic [DATA_W-1:0]    wr_data,
  input  logic                 iss_valid,
  input  logic [ADDR_W-1:0]    iss_dest,
  input  logic                 iss_wb,
  input  logic [ADDR_W-1:0]    iss_src_a,
  input  logic [ADDR_W-1:0]    iss_src_b,
  output logic                 hazard,
  output logic [2**ADDR_W-1:0] busy_vec
);
  localparam int unsigned NR = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NR];
  logic              wr_live;

  assign wr_live = wr_en && !(R0_ZERO && (wr_addr == ADDR_W'(REG_ZERO)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NR; i++) regs_q[i] <= '0;
    end else if (wr_live) begin
      regs_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    rd_data_a = regs_q[rd_addr_a];
    if (wr_live && (wr_addr == rd_addr_a)) rd_data_a = wr_data;
    if (R0_ZERO && (rd_addr_a == ADDR_W'(REG_ZERO))) rd_data_a = '0;
  end

  always_comb begin
    rd_data_b = regs_q[rd_addr_b];
    if (wr_live && (wr_addr == rd_addr_b)) rd_data_b = wr_data;
    if (R0_ZERO && (rd_addr_b == ADDR_W'(REG_ZERO))) rd_data_b = '0;
  end

  sb_tracker #(
    .ADDR_W  (ADDR_W),
    .R0_ZERO (R0_ZERO)
  ) u_sb_tracker (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .iss_valid (iss_valid),
    .iss_dest  (iss_dest),
    .iss_wb    (iss_wb),
    .iss_src_a (iss_src_a),
    .iss_src_b (iss_src_b),
    .hazard    (hazard),
    .busy_vec  (busy_vec)
  );
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed-vector bench for reg_file_scoreboard: reset, bypass, R0, RAW, set/clear race, WAW.
module tb_reg_file_scoreboard;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  rd_addr_a, rd_addr_b, wr_addr, iss_dest, iss_src_a, iss_src_b;
  logic [15:0] rd_data_a, rd_data_b, wr_data;
  logic        wr_en, iss_valid, iss_wb, hazard;
  logic [7:0]  busy_vec;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  reg_file_scoreboard dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rd_addr_a (rd_addr_a),
    .rd_data_a (rd_data_a),
    .rd_addr_b (rd_addr_b),
    .rd_data_b (rd_data_b),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .iss_valid (iss_valid),
    .iss_dest  (iss_dest),
    .iss_wb    (iss_wb),
    .iss_src_a (iss_src_a),
    .iss_src_b (iss_src_b),
    .hazard    (hazard),
    .busy_vec  (busy_vec)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    iss_valid = 1'b0; iss_dest = '0; iss_wb = 1'b0; iss_src_a = '0; iss_src_b = '0;
  endtask

  task automatic issue(input logic [2:0] dest, input logic wb, input logic [2:0] sa,
                       input logic [2:0] sb);
    iss_valid = 1'b1; iss_dest = dest; iss_wb = wb; iss_src_a = sa; iss_src_b = sb;
  endtask

  task automatic write(input logic [2:0] a, input logic [15:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
  endtask

  task automatic test_reset();
    write(3'd3, 16'h1234);
    issue(3'd1, 1'b1, 3'd0, 3'd0);
    tick(); idle(); rd_addr_a = 3'd3; #1;
    checks++; if (rd_data_a !== 16'h1234) begin errors++;
      $display("FAIL reset_pre_rd: got %h want %h", rd_data_a, 16'h1234); end
    checks++; if (busy_vec !== 8'h02) begin errors++;
      $display("FAIL reset_pre_busy: got %h want %h", busy_vec, 8'h02); end
    // Writes and issues during reset must be ignored.
    rst_n = 1'b0; write(3'd3, 16'h5555); issue(3'd2, 1'b1, 3'd0, 3'd0);
    tick(); rst_n = 1'b1; idle(); #1;
    checks++; if (rd_data_a !== 16'h0000) begin errors++;
      $display("FAIL reset_rd: got %h want %h", rd_data_a, 16'h0000); end
    checks++; if (busy_vec !== 8'h00) begin errors++;
      $display("FAIL reset_busy: got %h want %h", busy_vec, 8'h00); end
  endtask

  task automatic test_bypass();
    write(3'd5, 16'hBEEF); rd_addr_a = 3'd5; rd_addr_b = 3'd5; #1;
    checks++; if (rd_data_a !== 16'hBEEF) begin errors++;
      $display("FAIL bypass_a: got %h want %h", rd_data_a, 16'hBEEF); end
    checks++; if (rd_data_b !== 16'hBEEF) begin errors++;
      $display("FAIL bypass_b: got %h want %h", rd_data_b, 16'hBEEF); end
    tick(); idle(); rd_addr_b = 3'd3; #1;
    checks++; if (rd_data_a !== 16'hBEEF) begin errors++;
      $display("FAIL bypass_stored: got %h want %h", rd_data_a, 16'hBEEF); end
    checks++; if (rd_data_b !== 16'h0000) begin errors++;
      $display("FAIL bypass_other: got %h want %h", rd_data_b, 16'h0000); end
  endtask

  task automatic test_r0();
    write(3'd0, 16'hFFFF); rd_addr_a = 3'd0; #1;
    checks++; if (rd_data_a !== 16'h0000) begin errors++;
      $display("FAIL r0_bypass: got %h want %h", rd_data_a, 16'h0000); end
    tick(); idle(); #1;
    checks++; if (rd_data_a !== 16'h0000) begin errors++;
      $display("FAIL r0_stored: got %h want %h", rd_data_a, 16'h0000); end
    issue(3'd0, 1'b1, 3'd0, 3'd0); #1;
    checks++; if (hazard !== 1'b0) begin errors++;
      $display("FAIL r0_hazard: got %b want %b", hazard, 1'b0); end
    tick(); idle(); #1;
    checks++; if (busy_vec !== 8'h00) begin errors++;
      $display("FAIL r0_busy: got %h want %h", busy_vec, 8'h00); end
  endtask

  task automatic test_raw();
    issue(3'd2, 1'b1, 3'd0, 3'd0); #1;
    checks++; if (hazard !== 1'b0) begin errors++;
      $display("FAIL raw_first: got %b want %b", hazard, 1'b0); end
    tick(); idle(); #1;
    checks++; if (busy_vec !== 8'h04) begin errors++;
      $display("FAIL raw_busy: got %h want %h", busy_vec, 8'h04); end
    issue(3'd3, 1'b1, 3'd2, 3'd0); #1;
    checks++; if (hazard !== 1'b1) begin errors++;
      $display("FAIL raw_stall: got %b want %b", hazard, 1'b1); end
    tick(); #1;
    checks++; if (hazard !== 1'b1) begin errors++;
      $display("FAIL raw_stall2: got %b want %b", hazard, 1'b1); end
    checks++; if (busy_vec !== 8'h04) begin errors++;
      $display("FAIL raw_no_set: got %h want %h", busy_vec, 8'h04); end
    write(3'd2, 16'hA5A5); rd_addr_a = 3'd2; #1;
    checks++; if (hazard !== 1'b0) begin errors++;
      $display("FAIL raw_resolve: got %b want %b", hazard, 1'b0); end
    checks++; if (rd_data_a !== 16'hA5A5) begin errors++;
      $display("FAIL raw_bypass: got %h want %h", rd_data_a, 16'hA5A5); end
    tick(); idle(); #1;
    checks++; if (busy_vec !== 8'h08) begin errors++;
      $display("FAIL raw_after: got %h want %h", busy_vec, 8'h08); end
    write(3'd3, 16'h0033); tick(); idle(); #1;
    checks++; if (busy_vec !== 8'h00) begin errors++;
      $display("FAIL raw_clear: got %h want %h", busy_vec, 8'h00); end
  endtask

  task automatic test_race();
    issue(3'd4, 1'b1, 3'd0, 3'd0); tick(); idle(); #1;
    checks++; if (busy_vec !== 8'h10) begin errors++;
      $display("FAIL race_pre: got %h want %h", busy_vec, 8'h10); end
    write(3'd4, 16'h4444); issue(3'd4, 1'b1, 3'd0, 3'd0); #1;
    checks++; if (hazard !== 1'b0) begin errors++;
      $display("FAIL race_hazard: got %b want %b", hazard, 1'b0); end
    tick(); idle(); rd_addr_b = 3'd4; #1;
    checks++; if (busy_vec !== 8'h10) begin errors++;
      $display("FAIL race_busy: got %h want %h", busy_vec, 8'h10); end
    checks++; if (rd_data_b !== 16'h4444) begin errors++;
      $display("FAIL race_data: got %h want %h", rd_data_b, 16'h4444); end
    write(3'd4, 16'h0044); tick(); idle(); #1;
    checks++; if (busy_vec !== 8'h00) begin errors++;
      $display("FAIL race_clear: got %h want %h", busy_vec, 8'h00); end
  endtask

  task automatic test_waw_reset();
    issue(3'd6, 1'b1, 3'd0, 3'd0); tick(); idle(); #1;
    checks++; if (busy_vec !== 8'h40) begin errors++;
      $display("FAIL waw_busy: got %h want %h", busy_vec, 8'h40); end
    issue(3'd6, 1'b0, 3'd0, 3'd0); #1;
    checks++; if (hazard !== 1'b0) begin errors++;
      $display("FAIL waw_nowb: got %b want %b", hazard, 1'b0); end
    issue(3'd1, 1'b0, 3'd0, 3'd6); #1;
    checks++; if (hazard !== 1'b1) begin errors++;
      $display("FAIL raw_src_b: got %b want %b", hazard, 1'b1); end
    issue(3'd6, 1'b1, 3'd0, 3'd0); #1;
    checks++; if (hazard !== 1'b1) begin errors++;
      $display("FAIL waw_stall: got %b want %b", hazard, 1'b1); end
    rst_n = 1'b0; tick(); rst_n = 1'b1; #1;
    checks++; if (busy_vec !== 8'h00) begin errors++;
      $display("FAIL waw_rst_busy: got %h want %h", busy_vec, 8'h00); end
    checks++; if (hazard !== 1'b0) begin errors++;
      $display("FAIL waw_rst_hazard: got %b want %b", hazard, 1'b0); end
    idle();
  endtask

  initial begin
    rst_n = 1'b0; rd_addr_a = '0; rd_addr_b = '0; idle();
    tick(); tick(); rst_n = 1'b1;
    test_reset();
    test_bypass();
    test_r0();
    test_raw();
    test_race();
    test_waw_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
